fetch_scheduler: RTL and testbench
==================================

// Module: fetch_scheduler
// PURPOSE
//  Sequences instruction fetch into inst_buffer. Issues in-order 64-bit line reads (two
//  32-bit insts) to memory and paces them with credits against buffer occupancy.
//  Discards responses made stale by a squash and delivers IF_IB_PACKET pairs to the
//  inst_buffer write port. Sits between memory/icache and inst_buffer; it guarantees
//  the buffer is never written while full.
// PARAMETERS
//  DEPTH    16          inst_buffer entries (pairs); must equal buffer DEPTH
//  MAX_OUT  4           max memory requests in flight (issued, response not yet seen)
//  RESET_PC 0           first fetch address after reset (8-byte aligned)
//  CNT_W    $clog2(DEPTH+1)  occupancy/credit counter width (derived)
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low reset
//  squash         in   1      redirect; flush pending fetch stream
//  branch_target  in   XLEN   redirect PC; bit[2] selects slot 1 as first valid inst
//  buf_pop        in   1      inst_buffer retired one pair entry this cycle
//  mem_req_valid  out  1      line read request valid
//  mem_req_addr   out  XLEN   line address, bits[2:0]=0
//  mem_req_ready  in   1      memory accepts request when valid&&ready
//  mem_rsp_valid  in   1      response valid; responses return strictly in request order
//  mem_rsp_data   in   64     line data; [31:0]=slot 0, [63:32]=slot 1
//  if_ib_packet   out  IF_IB_PACKET[0:1]  pair to inst_buffer; [0].valid is write strobe
// BEHAVIOUR
//  - Reset (reset==0, async): mem_req_valid=0; mem_req_addr=RESET_PC; if_ib_packet all
//    fields 0; fetch_pc=RESET_PC; occupancy, outstanding, stale_cnt=0; skip0=0.
//  - Issue: mem_req_valid=1 when the request is not blocked and
//    outstanding<MAX_OUT and occupancy+live_out<DEPTH, where live_out=outstanding-stale_cnt.
//  - A request is accepted when mem_req_valid && mem_req_ready. Then outstanding+1 and
//    fetch_pc+8. Addr and valid hold stable while valid&&!ready. Valid is never withdrawn
//    before acceptance, including on squash.
//  - Response: when stale_cnt>0, drop it and decrement stale_cnt. Otherwise register it:
//    next cycle [1].valid=1, PC=line+4; [0].valid=~skip0, PC=line; inst from mem_rsp_data;
//    NPC=PC+4. Clear skip0 after the first delivered line. occupancy+1.
//    outstanding-1 on every response. Latency rsp->packet: 1 cycle.
//  - if_ib_packet valid bits are high for exactly one cycle per delivered line. With
//    skip0, occupancy still counts the pair ([0].valid=0 but [1].valid=1); the buffer write
//    strobe is [0].valid||[1].valid.
//  - buf_pop decrements occupancy. occupancy never underflows; ignore pop at 0.
//  - Squash (synchronous, highest priority):
//      fetch_pc={branch_target[XLEN-1:3],3'b0}; skip0=branch_target[2];
//      occupancy=0; that cycle's response is dropped; packet valids=0 next cycle;
//      stale_cnt=outstanding after this cycle's accept/response.
//    A request held unaccepted at squash keeps its old addr; it is marked stale on
//    acceptance (pending_stale flag) and counted into stale_cnt.
//    The first post-squash request issues the cycle after it (or after the held one is
//    accepted).
//  - FSM: FETCH (issuing), STALL (credit or MAX_OUT limit), HOLD (valid&&!ready).
//    FETCH->STALL on limit, STALL->FETCH when the limit clears, any->HOLD on
//    !ready, HOLD->FETCH/STALL on accept.
//  - Simultaneous pop+deliver: occupancy unchanged. Accept+response: outstanding
//    unchanged. Counters saturate-checked by assertion; never exceed DEPTH/MAX_OUT.
//  - fetch_pc wraps modulo 2^XLEN with no special handling.
// TESTING
//  1 Reset release, ready=1, no rsp -> requests at 0x0,0x8,0x10,0x18 on consecutive
//    cycles, then valid=0 (MAX_OUT=4).
//  2 rsp 1 cycle after accept, never pop -> exactly 16 pairs delivered, then valid=0.
//    One buf_pop -> exactly one more request.
//  3 Squash to 0x104 with 3 outstanding -> next req 0x100; 3 responses dropped; 4th gives
//    [0].valid=0, [1].PC=0x104, [1].NPC=0x108.
//  4 mem_req_ready=0 for 5 cycles, squash on cycle 2 -> addr stable; its response is
//    dropped; the following request is at the target.
//  5 Squash same cycle as mem_rsp_valid -> no packet next cycle; occupancy=0.
//  6 Assert reset mid-burst between clock edges -> mem_req_valid and packet valids go 0
//    immediately; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_scheduler_if.sv
// ============================================================================
// Module   : fetch_pkg / fetch_scheduler_if
// Purpose  : Shared fetch-side types and the memory/inst_buffer bus bundle
//            used by fetch_scheduler.
// Signals  : mem_req_valid/mem_req_addr/mem_req_ready  line read request
//            mem_rsp_valid/mem_rsp_data                in-order line response
//            if_ib_packet[0:1]                         pair to inst_buffer
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } if_ib_packet_t;
endpackage

interface fetch_scheduler_if;
  import fetch_pkg::*;

  logic                      mem_req_valid;
  logic [XLEN-1:0]           mem_req_addr;
  logic                      mem_req_ready;
  logic                      mem_rsp_valid;
  logic [63:0]               mem_rsp_data;
  if_ib_packet_t [0:1]       if_ib_packet;

  // master: the fetch scheduler; slave: memory plus inst_buffer side
  modport master (
    output mem_req_valid, mem_req_addr, if_ib_packet,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
  modport slave (
    input  mem_req_valid, mem_req_addr, if_ib_packet,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/fetch_scheduler.sv
// ============================================================================
// Module   : fetch_scheduler
// Purpose  : Issues in-order 64-bit line reads, paces them with credits
//            against inst_buffer occupancy, discards responses made stale by a
//            squash and writes instruction pairs into the inst_buffer.
// Ports    : clock          rising-edge clock
//            reset          asynchronous active-low reset
//            squash         redirect, flushes the pending fetch stream
//            branch_target  redirect PC, bit[2] skips slot 0 of first line
//            buf_pop        inst_buffer retired one pair entry
//            bus            fetch_scheduler_if.master (memory + packet side)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_scheduler
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 16,
  parameter int              MAX_OUT  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input wire                 clock,
  input wire                 reset,
  input wire                 squash,
  input wire [XLEN-1:0]      branch_target,
  input wire                 buf_pop,
  fetch_scheduler_if.master  bus
);

  localparam int              CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUT);
  localparam logic [XLEN-1:0]  C_LINE    = XLEN'(8);
  localparam logic [XLEN-1:0]  C_SLOT    = XLEN'(4);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [XLEN-1:0]     r_fetch_pc, r_hold_addr, r_rsp_pc;
  logic [CNT_W-1:0]    r_occ, r_out, r_stale;
  logic                r_skip0, r_pend_stale;
  if_ib_packet_t [0:1] r_pkt;

  logic                w_req_valid, w_accept, w_rsp_take, w_pop, w_credit_nxt;
  logic [XLEN-1:0]     w_req_addr, w_target_line;
  logic [CNT_W-1:0]    w_occ_nxt, w_out_nxt, w_stale_nxt;
  logic [CNT_W:0]      w_demand_nxt;
  logic                w_unused_target_lsb;

  // Valid depends only on registered state, so it cannot glitch with squash
  // and is never withdrawn while held.
  assign w_req_valid   = (r_state != ST_STALL);
  assign w_req_addr    = (r_state == ST_HOLD) ? r_hold_addr : r_fetch_pc;
  assign w_accept      = w_req_valid && bus.mem_req_ready;
  assign w_rsp_take    = bus.mem_rsp_valid && (r_stale == '0) && !squash;
  assign w_pop         = buf_pop && (r_occ != '0);
  assign w_target_line = {branch_target[XLEN-1:3], 3'b000};
  assign w_unused_target_lsb = ^branch_target[1:0];

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = w_req_addr;
  assign bus.if_ib_packet  = r_pkt;

  // Next counter values; the issue decision for next cycle is made from these
  // so that the state register alone decides mem_req_valid.
  always_comb begin
    w_out_nxt = r_out + CNT_W'(w_accept) - CNT_W'(bus.mem_rsp_valid);
    if (squash) begin
      w_occ_nxt   = '0;
      // everything still in flight after this cycle belongs to the old stream
      w_stale_nxt = w_out_nxt;
    end else begin
      w_occ_nxt   = r_occ + CNT_W'(w_rsp_take) - CNT_W'(w_pop);
      w_stale_nxt = r_stale
                  - CNT_W'(bus.mem_rsp_valid && (r_stale != '0))
                  + CNT_W'(w_accept && r_pend_stale);
    end
    // live_out = outstanding - stale; each live request reserves a buffer slot
    w_demand_nxt = {1'b0, w_occ_nxt} + {1'b0, w_out_nxt} - {1'b0, w_stale_nxt};
    w_credit_nxt = (w_out_nxt < C_MAX_OUT) && (w_demand_nxt < {1'b0, C_DEPTH});
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH, ST_HOLD: begin
        if (!bus.mem_req_ready)  w_state_nxt = ST_HOLD;
        else if (w_credit_nxt)   w_state_nxt = ST_FETCH;
        else                     w_state_nxt = ST_STALL;
      end
      ST_STALL: w_state_nxt = w_credit_nxt ? ST_FETCH : ST_STALL;
      default:  w_state_nxt = ST_STALL;
    endcase
  end

  // Reset lands in STALL so the request valid is low during reset; the first
  // edge after release moves to FETCH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_STALL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= RESET_PC;
      r_hold_addr  <= RESET_PC;
      r_rsp_pc     <= RESET_PC;
      r_occ        <= '0;
      r_out        <= '0;
      r_stale      <= '0;
      r_skip0      <= 1'b0;
      r_pend_stale <= 1'b0;
      r_pkt        <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_out   <= w_out_nxt;
      r_stale <= w_stale_nxt;

      if (w_req_valid && !bus.mem_req_ready) r_hold_addr <= w_req_addr;

      if (squash) begin
        r_fetch_pc   <= w_target_line;
        r_rsp_pc     <= w_target_line;
        r_skip0      <= branch_target[2];
        // a request still waiting for ready keeps its old address and is
        // counted stale once memory takes it
        r_pend_stale <= w_req_valid && !bus.mem_req_ready;
      end else begin
        // an accepted stale request does not advance the new stream's PC
        if (w_accept && !r_pend_stale) r_fetch_pc <= r_fetch_pc + C_LINE;
        if (w_accept)                  r_pend_stale <= 1'b0;
        if (w_rsp_take) begin
          r_rsp_pc <= r_rsp_pc + C_LINE;
          r_skip0  <= 1'b0;
        end
      end

      r_pkt[0].valid <= 1'b0;
      r_pkt[1].valid <= 1'b0;
      if (w_rsp_take) begin
        r_pkt[0].valid <= !r_skip0;
        r_pkt[0].inst  <= bus.mem_rsp_data[31:0];
        r_pkt[0].pc    <= r_rsp_pc;
        r_pkt[0].npc   <= r_rsp_pc + C_SLOT;
        r_pkt[1].valid <= 1'b1;
        r_pkt[1].inst  <= bus.mem_rsp_data[63:32];
        r_pkt[1].pc    <= r_rsp_pc + C_SLOT;
        r_pkt[1].npc   <= r_rsp_pc + C_LINE;
      end
    end
  end

  a_occ_bound:   assert property (@(posedge clock) disable iff (!reset) r_occ <= C_DEPTH);
  a_out_bound:   assert property (@(posedge clock) disable iff (!reset) r_out <= C_MAX_OUT);
  a_stale_bound: assert property (@(posedge clock) disable iff (!reset) r_stale <= r_out);
  a_rsp_expect:  assert property (@(posedge clock) disable iff (!reset)
                                  bus.mem_rsp_valid |-> (r_out != '0));
  a_no_full_wr:  assert property (@(posedge clock) disable iff (!reset)
                                  w_rsp_take |-> ((r_occ < C_DEPTH) || w_pop));

endmodule

`default_nettype wire

// File: tb/tb_fetch_scheduler.sv
// ============================================================================
// Module   : tb_fetch_scheduler
// Purpose  : Directed self-checking bench for fetch_scheduler with a simple
//            in-order memory model (response one cycle after acceptance).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_scheduler;
  import fetch_pkg::*;

  typedef if_ib_packet_t [0:1] pair_t;

  localparam logic [31:0] C_SIG = 32'hC0DE_0000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            squash = 1'b0;
  logic [XLEN-1:0] branch_target = '0;
  logic            buf_pop = 1'b0;

  fetch_scheduler_if bus();

  fetch_scheduler #(.DEPTH(16), .MAX_OUT(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .branch_target(branch_target), .buf_pop(buf_pop), .bus(bus)
  );

  always #5 clock = ~clock;

  int              n_checks = 0;
  int              n_pass   = 0;
  bit              ready_knob = 1'b1;
  bit              rsp_knob   = 1'b0;
  logic [XLEN-1:0] mq[$];
  logic [XLEN-1:0] req_log[$];
  pair_t           pkt_log[$];

  function automatic logic [63:0] line_data(input logic [XLEN-1:0] a);
    return {(a + 32'd4) ^ C_SIG, a ^ C_SIG};
  endfunction

  function automatic pair_t exp_pair(input logic [XLEN-1:0] line, input logic skip0);
    pair_t e;
    e[0].valid = !skip0;  e[0].inst = line ^ C_SIG;
    e[0].pc    = line;    e[0].npc  = line + 32'd4;
    e[1].valid = 1'b1;    e[1].inst = (line + 32'd4) ^ C_SIG;
    e[1].pc    = line + 32'd4; e[1].npc = line + 32'd8;
    return e;
  endfunction

  // One clock of memory model activity, then sample at posedge+1.
  task automatic step();
    logic [XLEN-1:0] a;
    bus.mem_req_ready = ready_knob;
    if (rsp_knob && mq.size() > 0) begin
      a = mq.pop_front();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = line_data(a);
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
    end
    if (bus.mem_req_valid && ready_knob) begin
      mq.push_back(bus.mem_req_addr);
      req_log.push_back(bus.mem_req_addr);
    end
    @(posedge clock);
    #1;
    if (bus.if_ib_packet[0].valid || bus.if_ib_packet[1].valid)
      pkt_log.push_back(bus.if_ib_packet);
  endtask

  task automatic test_reset();
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    #22;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.mem_req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h want 0", bus.mem_req_addr); else n_pass++;
    n_checks++; if (bus.if_ib_packet !== '0) $display("FAIL rst_packet: got %h want 0", bus.if_ib_packet); else n_pass++;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_issue();
    ready_knob = 1'b1; rsp_knob = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'(i * 8))
        $display("FAIL issue_req%0d: got valid %b addr %h want 1 %h", i, bus.mem_req_valid, bus.mem_req_addr, 32'(i * 8));
      else n_pass++;
      step();
    end
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL issue_maxout: got valid %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (req_log.size() !== 4) $display("FAIL issue_count: got %0d want 4", req_log.size()); else n_pass++;
  endtask

  task automatic test_credit();
    int bad = -1;
    rsp_knob = 1'b1;
    repeat (40) step();
    n_checks++; if (pkt_log.size() !== 16) $display("FAIL credit_pairs: got %0d want 16", pkt_log.size()); else n_pass++;
    for (int i = 0; i < pkt_log.size() && i < 16; i++)
      if (pkt_log[i] !== exp_pair(32'(i * 8), 1'b0) && bad < 0) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL credit_pair_seq: pair %0d got %h want %h", bad, pkt_log[bad], exp_pair(32'(bad * 8), 1'b0)); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL credit_full_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (req_log.size() !== 16) $display("FAIL credit_reqs: got %0d want 16", req_log.size()); else n_pass++;
    buf_pop = 1'b1; step(); buf_pop = 1'b0;
    repeat (10) step();
    n_checks++; if (req_log.size() !== 17) $display("FAIL pop_one_req: got %0d want 17", req_log.size()); else n_pass++;
    n_checks++; if (req_log[req_log.size()-1] !== 32'h80) $display("FAIL pop_req_addr: got %h want 80", req_log[req_log.size()-1]); else n_pass++;
    n_checks++; if (pkt_log.size() !== 17) $display("FAIL pop_pairs: got %0d want 17", pkt_log.size()); else n_pass++;
  endtask

  task automatic test_squash();
    int base;
    int bad = -1;
    pair_t p;
    rsp_knob = 1'b0;
    buf_pop = 1'b1; repeat (3) step(); buf_pop = 1'b0;
    step();
    n_checks++; if (mq.size() !== 3) $display("FAIL sq_outstanding: got %0d want 3", mq.size()); else n_pass++;
    squash = 1'b1; branch_target = 32'h104; step(); squash = 1'b0;
    n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h100) $display("FAIL sq_next_req: got %b %h want 1 100", bus.mem_req_valid, bus.mem_req_addr); else n_pass++;
    base = pkt_log.size();
    rsp_knob = 1'b1;
    repeat (40) step();
    n_checks++; if (pkt_log.size() - base !== 16) $display("FAIL sq_pairs: got %0d want 16", pkt_log.size() - base); else n_pass++;
    p = pkt_log[base];
    n_checks++; if (p !== exp_pair(32'h100, 1'b1)) $display("FAIL sq_first_pair: got %h want %h", p, exp_pair(32'h100, 1'b1)); else n_pass++;
    for (int i = 1; i < 16 && base + i < pkt_log.size(); i++)
      if (pkt_log[base+i] !== exp_pair(32'h100 + 32'(i * 8), 1'b0) && bad < 0) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL sq_pair_seq: pair %0d got %h want %h", bad, pkt_log[base+bad], exp_pair(32'h100 + 32'(bad * 8), 1'b0)); else n_pass++;
  endtask

  task automatic test_hold();
    int base;
    int idx;
    rsp_knob = 1'b1; ready_knob = 1'b0;
    buf_pop = 1'b1; step(); buf_pop = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin squash = 1'b1; branch_target = 32'h200; end
      step();
      squash = 1'b0;
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h180)
        $display("FAIL hold_stable_c%0d: got %b %h want 1 180", c, bus.mem_req_valid, bus.mem_req_addr);
      else n_pass++;
    end
    ready_knob = 1'b1;
    base = pkt_log.size();
    idx  = req_log.size();
    step();
    n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h200) $display("FAIL hold_next_req: got %b %h want 1 200", bus.mem_req_valid, bus.mem_req_addr); else n_pass++;
    repeat (40) step();
    n_checks++; if (req_log[idx] !== 32'h180 || req_log[idx+1] !== 32'h200) $display("FAIL hold_req_order: got %h %h want 180 200", req_log[idx], req_log[idx+1]); else n_pass++;
    n_checks++; if (pkt_log.size() - base !== 16) $display("FAIL hold_pairs: got %0d want 16", pkt_log.size() - base); else n_pass++;
    n_checks++; if (pkt_log[base] !== exp_pair(32'h200, 1'b0)) $display("FAIL hold_first_pair: got %h want %h", pkt_log[base], exp_pair(32'h200, 1'b0)); else n_pass++;
  endtask

  task automatic test_squash_rsp();
    int base;
    rsp_knob = 1'b0; ready_knob = 1'b1;
    buf_pop = 1'b1; step(); buf_pop = 1'b0;
    step();
    n_checks++; if (mq.size() !== 1 || mq[0] !== 32'h280) $display("FAIL sr_inflight: got %0d entries want 1 at 280", mq.size()); else n_pass++;
    base = pkt_log.size();
    rsp_knob = 1'b1; squash = 1'b1; branch_target = 32'h300; step(); squash = 1'b0;
    n_checks++; if (pkt_log.size() !== base) $display("FAIL sr_no_packet: got %0d packets want 0", pkt_log.size() - base); else n_pass++;
    n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h300) $display("FAIL sr_next_req: got %b %h want 1 300", bus.mem_req_valid, bus.mem_req_addr); else n_pass++;
    repeat (40) step();
    n_checks++; if (pkt_log.size() - base !== 16) $display("FAIL sr_pairs: got %0d want 16", pkt_log.size() - base); else n_pass++;
    n_checks++; if (pkt_log[base] !== exp_pair(32'h300, 1'b0)) $display("FAIL sr_first_pair: got %h want %h", pkt_log[base], exp_pair(32'h300, 1'b0)); else n_pass++;
  endtask

  task automatic test_async_reset();
    squash = 1'b1; branch_target = 32'h400; step(); squash = 1'b0;
    step(); step();
    n_checks++; if (bus.if_ib_packet[1].valid !== 1'b1 || bus.mem_req_valid !== 1'b1) $display("FAIL ar_burst: got pkt %b req %b want 1 1", bus.if_ib_packet[1].valid, bus.mem_req_valid); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL ar_req_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
    n_checks++; if (bus.if_ib_packet[0].valid !== 1'b0 || bus.if_ib_packet[1].valid !== 1'b0) $display("FAIL ar_pkt_valid: got %b %b want 0 0", bus.if_ib_packet[0].valid, bus.if_ib_packet[1].valid); else n_pass++;
    n_checks++; if (bus.mem_req_addr !== 32'h0) $display("FAIL ar_req_addr: got %h want 0", bus.mem_req_addr); else n_pass++;
    mq.delete();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) $display("FAIL ar_resume: got %b %h want 1 0", bus.mem_req_valid, bus.mem_req_addr); else n_pass++;
    req_log.delete();
    repeat (3) step();
    n_checks++; if (req_log.size() < 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h8) $display("FAIL ar_resume_seq: got %0d reqs, want 0 then 8", req_log.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_issue();
    test_credit();
    test_squash();
    test_hold();
    test_squash_rsp();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
